// File: rtl/exe_stage.sv
// Execute stage: ALU, data-SRAM request with req/addr_ok handshake, forwarding to MEM and bypass to decode.
// Optional cycle stall counter output enabled by defining EXE_STALL_CNT_EN.
module exe_stage #(
  parameter int ID_BUS_W  = 154,
  parameter int MEM_BUS_W = 71,
  parameter int BYP_W     = 38
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 id_to_exe_valid,
  output logic                 exe_allow_in,
  input  logic [ID_BUS_W-1:0]  id_to_exe_bus,
  input  logic                 mem_allow_in,
  output logic                 exe_to_mem_valid,
  output logic [MEM_BUS_W-1:0] exe_to_mem_bus,
  output logic                 exe_valid,
  output logic                 exe_is_load,
  output logic [BYP_W-1:0]     exe_to_id_bypass_bus,
  output logic                 data_sram_req,
  output logic                 data_sram_wr,
  output logic [3:0]           data_sram_wstrb,
  output logic [31:0]          data_sram_addr,
  output logic [31:0]          data_sram_wdata,
  input  logic                 data_sram_addr_ok
`ifdef EXE_STALL_CNT_EN
  ,
  output logic [31:0]          stall_cnt
`endif
);

  logic                exe_valid_r;
  logic                req_done_r;
  logic [ID_BUS_W-1:0] id_bus_r;

  logic [31:0] pc_s;
  logic [31:0] rj_value_s;
  logic [31:0] rkd_value_s;
  logic [31:0] imm_s;
  logic [11:0] alu_op_s;
  logic        src1_is_pc_s;
  logic        src2_is_imm_s;
  logic        res_from_mem_s;
  logic        reg_we_s;
  logic        mem_en_s;
  logic [3:0]  mem_we_s;
  logic [4:0]  reg_waddr_s;

  logic [31:0] src1_s;
  logic [31:0] src2_s;
  logic [4:0]  shamt_s;
  logic [31:0] sra_s;
  logic [31:0] alu_result_s;
  logic        exe_ready_go_s;
  logic        leave_s;

  assign {pc_s, rj_value_s, rkd_value_s, imm_s, alu_op_s, src1_is_pc_s, src2_is_imm_s,
          res_from_mem_s, reg_we_s, mem_en_s, mem_we_s, reg_waddr_s} = id_bus_r;

  assign src1_s  = src1_is_pc_s  ? pc_s  : rj_value_s;
  assign src2_s  = src2_is_imm_s ? imm_s : rkd_value_s;
  assign shamt_s = src2_s[4:0];
  assign sra_s   = $signed(src1_s) >>> shamt_s;

  // One-hot ALU select; any other encoding (including all-zero) yields 0.
  always_comb begin
    alu_result_s = 32'd0;
    case (alu_op_s)
      12'h001: alu_result_s = src1_s + src2_s;
      12'h002: alu_result_s = src1_s - src2_s;
      12'h004: alu_result_s = {31'd0, ($signed(src1_s) < $signed(src2_s))};
      12'h008: alu_result_s = {31'd0, (src1_s < src2_s)};
      12'h010: alu_result_s = src1_s & src2_s;
      12'h020: alu_result_s = ~(src1_s | src2_s);
      12'h040: alu_result_s = src1_s | src2_s;
      12'h080: alu_result_s = src1_s ^ src2_s;
      12'h100: alu_result_s = src1_s << shamt_s;
      12'h200: alu_result_s = src1_s >> shamt_s;
      12'h400: alu_result_s = sra_s;
      12'h800: alu_result_s = src2_s;
      default: alu_result_s = 32'd0;
    endcase
  end

  // An accepted request lets the instruction advance in the same cycle.
  assign data_sram_req    = exe_valid_r && mem_en_s && !req_done_r;
  assign exe_ready_go_s   = !mem_en_s || req_done_r || (data_sram_req && data_sram_addr_ok);
  assign exe_allow_in     = !exe_valid_r || (exe_ready_go_s && mem_allow_in);
  assign exe_to_mem_valid = exe_valid_r && exe_ready_go_s;
  assign leave_s          = exe_to_mem_valid && mem_allow_in;

  assign data_sram_wr    = |mem_we_s;
  assign data_sram_wstrb = mem_we_s;
  assign data_sram_addr  = alu_result_s;
  assign data_sram_wdata = rkd_value_s;

  assign exe_valid            = exe_valid_r;
  assign exe_is_load          = exe_valid_r && res_from_mem_s;
  assign exe_to_mem_bus       = {pc_s, res_from_mem_s, reg_we_s, reg_waddr_s, alu_result_s};
  assign exe_to_id_bypass_bus = {reg_we_s, reg_waddr_s, alu_result_s};

  // Stage valid bit and payload capture.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      exe_valid_r <= 1'b0;
      id_bus_r    <= '0;
    end else begin
      if (exe_allow_in) begin
        exe_valid_r <= id_to_exe_valid;
      end
      if (exe_allow_in && id_to_exe_valid) begin
        id_bus_r <= id_to_exe_bus;
      end
    end
  end

  // Leaving has priority so a same-cycle accept-and-leave ends with req_done clear.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      req_done_r <= 1'b0;
    end else if (leave_s) begin
      req_done_r <= 1'b0;
    end else if (data_sram_req && data_sram_addr_ok) begin
      req_done_r <= 1'b1;
    end
  end

`ifdef EXE_STALL_CNT_EN
  // Counts cycles an instruction sits in EXE without handing off to MEM.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      stall_cnt <= 32'd0;
    end else if (exe_valid_r && !leave_s) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_exe_stage.sv
// Scoreboard bench for exe_stage: directed scenarios plus randomized traffic against a reference model.
module tb_exe_stage;

  logic         clk = 1'b0;
  logic         resetn;
  logic         id_to_exe_valid;
  logic         exe_allow_in;
  logic [153:0] id_to_exe_bus;
  logic         mem_allow_in;
  logic         exe_to_mem_valid;
  logic [70:0]  exe_to_mem_bus;
  logic         exe_valid;
  logic         exe_is_load;
  logic [37:0]  exe_to_id_bypass_bus;
  logic         data_sram_req;
  logic         data_sram_wr;
  logic [3:0]   data_sram_wstrb;
  logic [31:0]  data_sram_addr;
  logic [31:0]  data_sram_wdata;
  logic         data_sram_addr_ok;
`ifdef EXE_STALL_CNT_EN
  logic [31:0]  stall_cnt;
`endif

  exe_stage dut (
`ifdef EXE_STALL_CNT_EN
    .stall_cnt            (stall_cnt),
`endif
    .clk                  (clk),
    .resetn               (resetn),
    .id_to_exe_valid      (id_to_exe_valid),
    .exe_allow_in         (exe_allow_in),
    .id_to_exe_bus        (id_to_exe_bus),
    .mem_allow_in         (mem_allow_in),
    .exe_to_mem_valid     (exe_to_mem_valid),
    .exe_to_mem_bus       (exe_to_mem_bus),
    .exe_valid            (exe_valid),
    .exe_is_load          (exe_is_load),
    .exe_to_id_bypass_bus (exe_to_id_bypass_bus),
    .data_sram_req        (data_sram_req),
    .data_sram_wr         (data_sram_wr),
    .data_sram_wstrb      (data_sram_wstrb),
    .data_sram_addr       (data_sram_addr),
    .data_sram_wdata      (data_sram_wdata),
    .data_sram_addr_ok    (data_sram_addr_ok)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc, rj, rkd, imm;
    int          op;       // 0..11 operation index, 12 = no operation
    logic        s1pc, s2imm, rfm, rwe, men;
    logic [3:0]  mwe;
    logic [4:0]  wa;
  } instr_t;

  typedef struct packed {
    logic        ld;
    logic [37:0] byp;
    logic [70:0] bus;
  } exp_t;

  exp_t        out_q[$];
  logic [68:0] req_q[$];
  instr_t      cur;
  int          n_chk = 0;
  int          n_fail = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [153:0] pack(input instr_t i);
    logic [11:0] oh;
    oh = (i.op < 12) ? (12'd1 << i.op) : 12'd0;
    return {i.pc, i.rj, i.rkd, i.imm, oh, i.s1pc, i.s2imm, i.rfm, i.rwe, i.men, i.mwe, i.wa};
  endfunction

  function automatic logic [31:0] model(input instr_t i);
    logic [31:0] a, b;
    logic [63:0] w;
    int sh;
    a  = i.s1pc ? i.pc : i.rj;
    b  = i.s2imm ? i.imm : i.rkd;
    sh = int'(b % 32);
    case (i.op)
      0:  return a + b;
      1:  return a - b;
      2:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3:  return (a < b) ? 32'd1 : 32'd0;
      4:  return a & b;
      5:  return ~(a | b);
      6:  return a | b;
      7:  return a ^ b;
      8:  return a << sh;
      9:  return a >> sh;
      10: begin w = {{32{a[31]}}, a} >> sh; return w[31:0]; end
      11: return b;
      default: return 32'd0;
    endcase
  endfunction

  function automatic instr_t mk(input int op, input logic [31:0] rj, input logic [31:0] rkd,
                                input logic [31:0] imm, input logic s2imm);
    instr_t i;
    i.pc = 32'h1c00_0100; i.rj = rj; i.rkd = rkd; i.imm = imm; i.op = op;
    i.s1pc = 1'b0; i.s2imm = s2imm; i.rfm = 1'b0; i.rwe = 1'b1; i.men = 1'b0;
    i.mwe = 4'h0; i.wa = 5'd3;
    return i;
  endfunction

  function automatic instr_t rnd_instr();
    instr_t i;
    i.pc = $urandom; i.rj = $urandom; i.rkd = $urandom;
    i.imm = ($urandom_range(0, 1) == 0) ? $urandom : $urandom_range(0, 40);
    i.op = $urandom_range(0, 12);
    i.s1pc = ($urandom_range(0, 3) == 0);
    i.s2imm = ($urandom_range(0, 1) == 0);
    i.men = ($urandom_range(0, 2) == 0);
    i.wa = 5'($urandom_range(0, 31));
    if (i.men && $urandom_range(0, 1) == 0) begin
      i.mwe = 4'($urandom_range(1, 15)); i.rfm = 1'b0; i.rwe = 1'b0;
    end else if (i.men) begin
      i.mwe = 4'h0; i.rfm = 1'b1; i.rwe = 1'b1;
    end else begin
      i.mwe = 4'h0; i.rfm = 1'b0; i.rwe = ($urandom_range(0, 1) == 0);
    end
    return i;
  endfunction

  task automatic drive(input instr_t i);
    cur = i;
    id_to_exe_bus = pack(i);
    id_to_exe_valid = 1'b1;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  // Scoreboard push: an instruction accepted into EXE defines its expected outputs.
  always @(negedge clk) begin
    logic [31:0] r;
    if (resetn && id_to_exe_valid && exe_allow_in) begin
      r = model(cur);
      out_q.push_back({cur.rfm, {cur.rwe, cur.wa, r}, {cur.pc, cur.rfm, cur.rwe, cur.wa, r}});
      if (cur.men) req_q.push_back({(cur.mwe != 4'h0), cur.mwe, r, cur.rkd});
    end
  end

  // Monitor: compare every handoff and every accepted SRAM request, and check stalled requests stay put.
  logic        hold_v = 1'b0;
  logic [68:0] hold_d;
  always @(negedge clk) begin
    exp_t        e;
    logic [68:0] rq;
    rq = {data_sram_wr, data_sram_wstrb, data_sram_addr, data_sram_wdata};
    if (!resetn) begin
      hold_v = 1'b0;
    end else begin
      if (hold_v) begin
        chk("req_held", 128'(data_sram_req), 128'(1'b1));
        chk("req_stable", 128'(rq), 128'(hold_d));
      end
      hold_v = data_sram_req && !data_sram_addr_ok;
      hold_d = rq;
      if (data_sram_req && data_sram_addr_ok) begin
        if (req_q.size() == 0) chk("req_unexpected", 128'(data_sram_req), 128'(1'b0));
        else chk("sram_req", 128'(rq), 128'(req_q.pop_front()));
      end
      if (exe_to_mem_valid && mem_allow_in) begin
        if (out_q.size() == 0) begin
          chk("out_unexpected", 128'(exe_to_mem_valid), 128'(1'b0));
        end else begin
          e = out_q.pop_front();
          chk("mem_bus", 128'(exe_to_mem_bus), 128'(e.bus));
          chk("bypass", 128'(exe_to_id_bypass_bus), 128'(e.byp));
          chk("is_load", 128'(exe_is_load), 128'(e.ld));
        end
      end
    end
  end

  initial begin
    instr_t      t;
    logic [37:0] eb;
    logic        acc;
    int          sent, cyc;
`ifdef EXE_STALL_CNT_EN
    logic [31:0] s0;
`endif
    resetn = 1'b0; id_to_exe_valid = 1'b0; id_to_exe_bus = '0;
    mem_allow_in = 1'b0; data_sram_addr_ok = 1'b0;
    cur = mk(12, 32'd0, 32'd0, 32'd0, 1'b0);
    repeat (3) smp();
    chk("rst_exe_valid", 128'(exe_valid), 128'(1'b0));
    chk("rst_allow_in", 128'(exe_allow_in), 128'(1'b1));
    chk("rst_to_mem_valid", 128'(exe_to_mem_valid), 128'(1'b0));
    chk("rst_req", 128'(data_sram_req), 128'(1'b0));
    chk("rst_is_load", 128'(exe_is_load), 128'(1'b0));
    chk("rst_mem_bus", 128'(exe_to_mem_bus), 128'd0);
    chk("rst_bypass", 128'(exe_to_id_bypass_bus), 128'd0);
`ifdef EXE_STALL_CNT_EN
    chk("rst_stall_cnt", 128'(stall_cnt), 128'd0);
`endif

    // add.w 5 + 7
    step(); resetn = 1'b1; mem_allow_in = 1'b1;
    drive(mk(0, 32'd5, 32'd7, 32'd0, 1'b0));
    smp(); step(); id_to_exe_valid = 1'b0;
    smp();
    eb = {1'b1, 5'd3, 32'd12};
    chk("add_to_mem_valid", 128'(exe_to_mem_valid), 128'(1'b1));
    chk("add_result", 128'(exe_to_mem_bus[31:0]), 128'(32'd12));
    chk("add_bypass", 128'(exe_to_id_bypass_bus), 128'(eb));
    step(); smp();
    chk("add_gone", 128'(exe_valid), 128'(1'b0));

    // sra, sltu, slt boundary operands
    for (int k = 0; k < 3; k++) begin
      case (k)
        0: t = mk(10, 32'h8000_0000, 32'h8000_0000, 32'd4, 1'b1);
        1: t = mk(3, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0);
        default: t = mk(2, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0);
      endcase
      t.rj = (k == 0) ? 32'h8000_0000 : 32'hFFFF_FFFF;
      step(); drive(t); smp(); step(); id_to_exe_valid = 1'b0; smp();
      case (k)
        0: chk("sra", 128'(exe_to_id_bypass_bus[31:0]), 128'(32'hF800_0000));
        1: chk("sltu", 128'(exe_to_id_bypass_bus[31:0]), 128'(32'd0));
        default: chk("slt", 128'(exe_to_id_bypass_bus[31:0]), 128'(32'd1));
      endcase
    end

    // st.w with addr_ok low for 3 cycles
    t = mk(0, 32'h0000_1000, 32'hDEAD_BEEF, 32'd8, 1'b1);
    t.men = 1'b1; t.mwe = 4'hF; t.rwe = 1'b0;
    step(); data_sram_addr_ok = 1'b0; drive(t);
    smp();
`ifdef EXE_STALL_CNT_EN
    s0 = stall_cnt;
`endif
    step(); id_to_exe_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      smp();
      chk("st_req", 128'(data_sram_req), 128'(1'b1));
      chk("st_addr", 128'(data_sram_addr), 128'(32'h0000_1008));
      chk("st_wdata", 128'(data_sram_wdata), 128'(32'hDEAD_BEEF));
      chk("st_wstrb", 128'(data_sram_wstrb), 128'(4'hF));
      chk("st_allow_in", 128'(exe_allow_in), 128'(1'b0));
      step();
    end
    data_sram_addr_ok = 1'b1;
    smp();
    chk("st_to_mem_valid", 128'(exe_to_mem_valid), 128'(1'b1));
    step(); data_sram_addr_ok = 1'b0; smp();
    chk("st_req_drop", 128'(data_sram_req), 128'(1'b0));
`ifdef EXE_STALL_CNT_EN
    chk("st_stall_cnt", 128'(stall_cnt - s0), 128'(32'd3));
`endif

    // ld.w accepted while MEM is blocked for 2 cycles
    t = mk(0, 32'h0000_2000, 32'd0, 32'd4, 1'b1);
    t.men = 1'b1; t.rfm = 1'b1; t.wa = 5'd9;
    step(); mem_allow_in = 1'b0; data_sram_addr_ok = 1'b1; drive(t);
    smp(); step(); id_to_exe_valid = 1'b0;
    smp();
    chk("ld_req", 128'(data_sram_req), 128'(1'b1));
    chk("ld_is_load", 128'(exe_is_load), 128'(1'b1));
    chk("ld_allow_in", 128'(exe_allow_in), 128'(1'b0));
    step(); smp();
    chk("ld_no_reissue", 128'(data_sram_req), 128'(1'b0));
    chk("ld_is_load_held", 128'(exe_is_load), 128'(1'b1));
    chk("ld_ready", 128'(exe_to_mem_valid), 128'(1'b1));
    step(); mem_allow_in = 1'b1; data_sram_addr_ok = 1'b0; smp();
    chk("ld_leave", 128'(exe_to_mem_valid), 128'(1'b1));
    step(); smp();
    chk("ld_gone", 128'(exe_valid), 128'(1'b0));

    // A fresh store after the load must issue a new request (req_done cleared)
    t = mk(0, 32'h0000_3000, 32'h1234_5678, 32'd0, 1'b1);
    t.men = 1'b1; t.mwe = 4'h3; t.rwe = 1'b0;
    step(); drive(t); smp(); step(); id_to_exe_valid = 1'b0; smp();
    chk("st2_req", 128'(data_sram_req), 128'(1'b1));

    // Asynchronous reset in the middle of that stalled request
    #2 resetn = 1'b0;
    #1;
    chk("arst_req", 128'(data_sram_req), 128'(1'b0));
    chk("arst_exe_valid", 128'(exe_valid), 128'(1'b0));
    chk("arst_to_mem_valid", 128'(exe_to_mem_valid), 128'(1'b0));
    chk("arst_allow_in", 128'(exe_allow_in), 128'(1'b1));
    out_q.delete(); req_q.delete();
    repeat (2) smp();
    step(); resetn = 1'b1;

    // Randomized traffic with random backpressure and addr_ok
    sent = 0; acc = 1'b0; cyc = 0;
    while ((sent < 300 || id_to_exe_valid) && cyc < 8000) begin
      mem_allow_in = ($urandom_range(0, 3) != 0);
      data_sram_addr_ok = ($urandom_range(0, 2) != 0);
      if (!id_to_exe_valid || acc) begin
        if (sent < 300 && $urandom_range(0, 4) != 0) begin
          drive(rnd_instr());
          sent++;
        end else begin
          id_to_exe_valid = 1'b0;
        end
      end
      smp();
      acc = id_to_exe_valid && exe_allow_in;
      step();
      cyc++;
    end
    chk("rand_timeout", 128'(cyc < 8000), 128'(1'b1));
    id_to_exe_valid = 1'b0; mem_allow_in = 1'b1; data_sram_addr_ok = 1'b1;
    repeat (10) step();
    smp();
    chk("drain_out_q", 128'(out_q.size()), 128'd0);
    chk("drain_req_q", 128'(req_q.size()), 128'd0);
    chk("drain_exe_valid", 128'(exe_valid), 128'(1'b0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
